// File: rtl/sram_pkg.sv
// Shared types and default parameters for the SRAM request queue.
package sram_pkg;

  localparam int DEPTH_DEFAULT   = 4;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int ADDR_W          = 4;
  localparam int DATA_W          = 8;
  localparam int TOUT_W          = 8;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_req_queue_if.sv
// Request, response and controller signals of the SRAM request queue.
interface sram_req_queue_if;
  import sram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_wr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              ctl_rd;
  logic              ctl_wr;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic [DATA_W-1:0] ctl_rdata;
  logic              ctl_ready;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, ctl_rdata, ctl_ready,
    input  req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err,
           ctl_rd, ctl_wr, ctl_addr, ctl_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, ctl_rdata, ctl_ready,
    output req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err,
           ctl_rd, ctl_wr, ctl_addr, ctl_wdata
  );

endinterface

// File: rtl/sram_req_fifo.sv
// Request FIFO: power-of-two depth, fixed-width entries, combinational head read.
module sram_req_fifo
  import sram_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [REQ_W-1:0]       wdata_i,
  output logic [REQ_W-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sram_req_queue.sv
// Queues SRAM requests and issues them one at a time to a controller,
// aborting any access that does not complete within TIMEOUT wait cycles.
module sram_req_queue
  import sram_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_req_queue_if.slave        bus,
  output logic                   busy_o,
  output logic                   timeout_err_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  req_t              cur_q, cur_d;
  req_t              head;
  logic [REQ_W-1:0]  head_bits;
  logic [TOUT_W-1:0] tcnt_q, tcnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              tout_q, tout_d;
  logic              fifo_full, fifo_empty, push, pop;

  assign push          = bus.req_valid && !fifo_full;
  assign bus.req_ready = !fifo_full;
  assign head          = req_t'(head_bits);

  sram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.req_wr, bus.req_addr, bus.req_wdata}),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign bus.ctl_wr    = (state_q == ISSUE) && cur_q.wr;
  assign bus.ctl_rd    = (state_q == ISSUE) && !cur_q.wr;
  assign bus.ctl_addr  = cur_q.addr;
  assign bus.ctl_wdata = cur_q.wdata;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy_o        = (state_q != IDLE) || !fifo_empty;
  assign timeout_err_o = tout_q;

  // Completion wins over timeout when ctl_ready arrives in the last allowed cycle.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = 1'b0;
    rsp_wr_d    = rsp_wr_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    tout_d      = tout_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ctl_ready) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = cur_q.wr;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = cur_q.wr ? '0 : bus.ctl_rdata;
          state_d     = IDLE;
        end else if (tcnt_q == TOUT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = cur_q.wr;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          tout_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          tcnt_d = tcnt_q + TOUT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      tcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      tcnt_q      <= tcnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      tout_q      <= tout_d;
    end
  end

endmodule

// File: tb/tb_sram_req_queue.sv
// Directed bench for sram_req_queue with a small SRAM controller model that
// answers three wait cycles after each issue unless stalled.
module tb_sram_req_queue;
  import sram_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic       timeout_err;
  logic [2:0] fifo_count;
  logic       stall = 1'b0;
  logic       forceReady = 1'b0;
  logic       acc;
  int         checks = 0;
  int         errors = 0;

  sram_req_queue_if bus ();

  sram_req_queue #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .busy_o        (busy),
    .timeout_err_o (timeout_err),
    .fifo_count_o  (fifo_count)
  );

  always #5 clk = ~clk;

  // Controller model: ready pulse in the third wait cycle after an issue, frozen while stalled.
  initial begin
    int         lat;
    logic       fire;
    logic [7:0] rdHold;
    logic [7:0] mem [16];
    lat = 0;
    rdHold = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    bus.ctl_ready = 1'b0;
    bus.ctl_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      fire = 1'b0;
      if (reset) lat = 0;
      else if (lat > 0 && !stall) begin
        lat--;
        fire = (lat == 0);
      end
      bus.ctl_ready = fire | forceReady;
      bus.ctl_rdata = fire ? rdHold : 8'h5A;
      if (!reset && (bus.ctl_rd || bus.ctl_wr)) begin
        lat = 3;
        if (bus.ctl_wr) begin
          mem[bus.ctl_addr] = bus.ctl_wdata;
          rdHold = 8'hC3;
        end else begin
          rdHold = mem[bus.ctl_addr];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                               output logic accepted);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    accepted      = bus.req_ready;
    tick(1);
    bus.req_valid = 1'b0;
  endtask

  task automatic expectRsp(input string tag, input int expDelay, input logic expWr,
                           input logic [7:0] expData, input logic expErr);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (bus.rsp_valid !== 1'b1 && n < expDelay + 30);
    checkOutput({tag, "_delay"}, 32'(n), 32'(expDelay));
    checkOutput({tag, "_wr"}, 32'(bus.rsp_wr), 32'(expWr));
    checkOutput({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(expData));
    checkOutput({tag, "_err"}, 32'(bus.rsp_err), 32'(expErr));
  endtask

  task automatic expectQuiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (bus.rsp_valid === 1'b1 || bus.ctl_rd === 1'b1 || bus.ctl_wr === 1'b1) pulses++;
    end
    checkOutput({tag, "_pulses"}, 32'(pulses), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 4'h0;
    bus.req_wdata = 8'h00;

    $display("[TB] reset values");
    tick(2);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_ctl_strobes", 32'({bus.ctl_rd, bus.ctl_wr}), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick(1);

    $display("[TB] write then read");
    applyStimulus(1'b1, 4'h3, 8'hA5, acc);
    checkOutput("wr_count", 32'(fifo_count), 32'd1);
    checkOutput("wr_busy", 32'(busy), 32'd1);
    checkOutput("wr_pre_issue", 32'(bus.ctl_wr), 32'd0);
    tick(1);
    checkOutput("wr_issue_wr", 32'(bus.ctl_wr), 32'd1);
    checkOutput("wr_issue_rd", 32'(bus.ctl_rd), 32'd0);
    checkOutput("wr_issue_addr", 32'(bus.ctl_addr), 32'h3);
    checkOutput("wr_issue_wdata", 32'(bus.ctl_wdata), 32'hA5);
    tick(1);
    checkOutput("wr_post_issue", 32'(bus.ctl_wr), 32'd0);
    checkOutput("wr_addr_held", 32'(bus.ctl_addr), 32'h3);
    expectRsp("wr_rsp", 3, 1'b1, 8'h00, 1'b0);
    tick(1);
    checkOutput("wr_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    applyStimulus(1'b0, 4'h3, 8'h00, acc);
    expectRsp("rd_rsp", 5, 1'b0, 8'hA5, 1'b0);

    $display("[TB] full fifo behind a stalled request");
    stall = 1'b1;
    applyStimulus(1'b0, 4'h1, 8'h00, acc);
    tick(2);
    checkOutput("full_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'(4 + i), 8'h00, acc);
      checkOutput($sformatf("full_acc%0d", i), 32'(acc), (i < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("full_cnt%0d", i), 32'(fifo_count), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    checkOutput("full_req_ready", 32'(bus.req_ready), 32'd0);
    stall = 1'b0;
    expectRsp("full_p0", 3, 1'b0, 8'h11, 1'b0);
    for (int i = 0; i < 4; i++)
      expectRsp($sformatf("full_q%0d", i), 5, 1'b0, 8'h14 + 8'(i), 1'b0);
    expectQuiet("full_extra", 12);

    $display("[TB] timeout abort");
    stall = 1'b1;
    applyStimulus(1'b0, 4'h2, 8'h00, acc);
    applyStimulus(1'b0, 4'h5, 8'h00, acc);
    expectRsp("tout_abort", 16, 1'b0, 8'h00, 1'b1);
    checkOutput("tout_sticky", 32'(timeout_err), 32'd1);
    stall = 1'b0;
    expectRsp("tout_next", 5, 1'b0, 8'h15, 1'b0);
    tick(1);
    checkOutput("tout_still", 32'(timeout_err), 32'd1);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 4'h3, 8'h13, acc);
    expectRsp("pre_wr", 5, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'(i), 8'h00, acc);
    expectRsp("b2b_r0", 2, 1'b0, 8'h10, 1'b0);
    for (int i = 1; i < 4; i++)
      expectRsp($sformatf("b2b_r%0d", i), 5, 1'b0, 8'h10 + 8'(i), 1'b0);

    $display("[TB] spurious ready in idle");
    tick(2);
    forceReady = 1'b1;
    tick(1);
    forceReady = 1'b0;
    expectQuiet("spur", 6);
    applyStimulus(1'b0, 4'h6, 8'h00, acc);
    expectRsp("spur_after", 5, 1'b0, 8'h16, 1'b0);

    $display("[TB] reset while waiting");
    stall = 1'b1;
    applyStimulus(1'b0, 4'h7, 8'h00, acc);
    applyStimulus(1'b0, 4'h8, 8'h00, acc);
    applyStimulus(1'b0, 4'h9, 8'h00, acc);
    checkOutput("mid_count", 32'(fifo_count), 32'd2);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("mid_rst_rsp", 32'({bus.rsp_valid, bus.rsp_wr, bus.rsp_err}), 32'd0);
    checkOutput("mid_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    checkOutput("mid_rst_ctl", 32'({bus.ctl_rd, bus.ctl_wr, bus.ctl_addr, bus.ctl_wdata}), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_tout", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    expectQuiet("mid_quiet", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
